// File: rtl/panel_pkg.sv
// panel_pkg: shared definitions for the clock/calendar front-panel logic.
//   btn_state_t  - per-button conditioner FSM states
//   DEB_20MS     - default debounce length, 20 ms at 50 MHz
//   HOLD_0_5S    - default delay from press pulse to first repeat, 0.5 s at 50 MHz
//   REP_0_25S    - default auto-repeat period, 0.25 s at 50 MHz
//   max3()       - largest of three integers, used to size shared counters
package panel_pkg;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      DEB_PRESS   = 2'd1,
      PRESSED     = 2'd2,
      DEB_RELEASE = 2'd3
   } btn_state_t;

   localparam int DEB_20MS  = 32'sd1_000_000;
   localparam int HOLD_0_5S = 32'sd25_000_000;
   localparam int REP_0_25S = 32'sd12_500_000;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) begin
         m = b;
      end else begin
         m = m;
      end
      if (c > m) begin
         m = c;
      end else begin
         m = m;
      end
      return m;
   endfunction

endpackage

// File: rtl/button_channel.sv
// button_channel: conditions one raw active-low push-button.
//   clk       - system clock
//   rst       - asynchronous active-high reset
//   i_butt_n  - raw button, active-low, asynchronous to clk
//   o_pulse   - one-cycle strobe on an accepted press and on each auto-repeat
//   o_held    - debounced pressed level
// A 2-flop synchronizer feeds a four-state debounce FSM. A saturating
// debounce counter (r_cnt) qualifies presses and releases; a saturating
// repeat counter (r_rcnt) times the hold-to-repeat strobes and only runs
// while the FSM sits in PRESSED, so a short release glitch pauses it.
module button_channel
   import panel_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEB_20MS,
   parameter int HOLD_CYCLES     = HOLD_0_5S,
   parameter int REPEAT_CYCLES   = REP_0_25S
)(
   input  logic clk,
   input  logic rst,
   input  logic i_butt_n,
   output logic o_pulse,
   output logic o_held
);

   localparam int MAXP = max3(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
   localparam int CW   = $clog2(MAXP) + 32'sd1;

   localparam logic [CW-1:0] DEB_C   = CW'(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] HOLD_C  = CW'(HOLD_CYCLES);
   localparam logic [CW-1:0] REP_C   = CW'(REPEAT_CYCLES);
   localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
   localparam logic [CW-1:0] ONE_C   = CW'(1'b1);
   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

   logic          r_s1;
   logic          r_s2;
   btn_state_t    r_state;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] r_rcnt;
   logic          r_rep_phase;   // 0: waiting for first repeat, 1: periodic repeats
   logic          r_pulse;
   logic          r_held;

   logic [CW-1:0] w_cnt_inc;
   logic [CW-1:0] w_rcnt_inc;
   logic          w_fire;

   assign o_pulse = r_pulse;
   assign o_held  = r_held;

   // Two-flop synchronizer, reset to the released level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1 <= 1'b1;
         r_s2 <= 1'b1;
      end else begin
         r_s1 <= i_butt_n;
         r_s2 <= r_s1;
      end
   end

   // Saturating increments and the repeat-fire decision for this edge.
   always_comb begin
      w_cnt_inc  = r_cnt;
      w_rcnt_inc = r_rcnt;
      w_fire     = 1'b0;
      if (r_cnt != CNT_MAX) begin
         w_cnt_inc = r_cnt + ONE_C;
      end else begin
         w_cnt_inc = r_cnt;
      end
      if (r_rcnt != CNT_MAX) begin
         w_rcnt_inc = r_rcnt + ONE_C;
      end else begin
         w_rcnt_inc = r_rcnt;
      end
      // A zero hold time disables auto-repeat entirely.
      if (r_rep_phase) begin
         w_fire = (w_rcnt_inc == REP_C);
      end else begin
         w_fire = (HOLD_C != ZERO_C) && (w_rcnt_inc == HOLD_C);
      end
   end

   // Debounce / repeat FSM with registered pulse and held outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cnt       <= ZERO_C;
         r_rcnt      <= ZERO_C;
         r_rep_phase <= 1'b0;
         r_pulse     <= 1'b0;
         r_held      <= 1'b0;
      end else begin
         r_pulse <= 1'b0;
         case (r_state)
            IDLE: begin
               // r_cnt is zero here, so w_cnt_inc == DEB_C only when the
               // debounce length is one sample: accept immediately.
               if (!r_s2) begin
                  if (w_cnt_inc == DEB_C) begin
                     r_state     <= PRESSED;
                     r_pulse     <= ~r_pulse;
                     r_held      <= 1'b1;
                     r_rcnt      <= ZERO_C;
                     r_rep_phase <= 1'b0;
                     r_cnt       <= ZERO_C;
                  end else begin
                     r_state <= DEB_PRESS;
                     r_cnt   <= w_cnt_inc;
                  end
               end else begin
                  r_cnt <= ZERO_C;
               end
            end
            DEB_PRESS: begin
               if (r_s2) begin
                  r_state <= IDLE;
                  r_cnt   <= ZERO_C;
               end else if (w_cnt_inc == DEB_C) begin
                  r_state     <= PRESSED;
                  r_pulse     <= ~r_pulse;
                  r_held      <= 1'b1;
                  r_rcnt      <= ZERO_C;
                  r_rep_phase <= 1'b0;
                  r_cnt       <= ZERO_C;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            PRESSED: begin
               // Repeat timing advances on every edge spent in PRESSED;
               // ~r_pulse keeps strobes from ever touching back to back.
               if (w_fire) begin
                  r_pulse     <= ~r_pulse;
                  r_rcnt      <= ZERO_C;
                  r_rep_phase <= 1'b1;
               end else begin
                  r_rcnt <= w_rcnt_inc;
               end
               if (r_s2) begin
                  if (w_cnt_inc == DEB_C) begin
                     r_state <= IDLE;
                     r_held  <= 1'b0;
                     r_cnt   <= ZERO_C;
                  end else begin
                     r_state <= DEB_RELEASE;
                     r_cnt   <= w_cnt_inc;
                  end
               end else begin
                  r_cnt <= ZERO_C;
               end
            end
            DEB_RELEASE: begin
               if (!r_s2) begin
                  r_state <= PRESSED;
                  r_cnt   <= ZERO_C;
               end else if (w_cnt_inc == DEB_C) begin
                  r_state <= IDLE;
                  r_held  <= 1'b0;
                  r_cnt   <= ZERO_C;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            default: begin
               r_state <= IDLE;
               r_held  <= 1'b0;
               r_cnt   <= ZERO_C;
            end
         endcase
      end
   end

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: front-panel push-button conditioner.
//   clk     - 50 MHz system clock
//   rst     - asynchronous active-high reset
//   butt_n  - raw active-low buttons, one bit per channel
//   pulse   - one-cycle strobe per accepted press and per auto-repeat
//   held    - debounced pressed level per channel
// Channels are fully independent; arbitration between simultaneous
// buttons is left to the consumer.
module button_conditioner
   import panel_pkg::*;
#(
   parameter int NUM_BUTTONS     = 32'sd3,
   parameter int DEBOUNCE_CYCLES = DEB_20MS,
   parameter int HOLD_CYCLES     = HOLD_0_5S,
   parameter int REPEAT_CYCLES   = REP_0_25S
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_BUTTONS-1:0] butt_n,
   output logic [NUM_BUTTONS-1:0] pulse,
   output logic [NUM_BUTTONS-1:0] held
);

   for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_ch
      button_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .HOLD_CYCLES     (HOLD_CYCLES),
         .REPEAT_CYCLES   (REPEAT_CYCLES)
      ) u_channel (
         .clk      (clk),
         .rst      (rst),
         .i_butt_n (butt_n[g]),
         .o_pulse  (pulse[g]),
         .o_held   (held[g])
      );
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios followed by
// random bouncing, compared cycle by cycle against a behavioural model that
// works from sample histories (run lengths, hold time) rather than FSM states.
module tb_button_conditioner;

   localparam int NB   = 3;
   localparam int DEB  = 4;
   localparam int HOLD = 10;
   localparam int REP  = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NB-1:0] butt_n = 3'b111;
   logic [NB-1:0] pulse, held, pulse_nh, held_nh;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   button_conditioner #(
      .NUM_BUTTONS(NB), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
   ) dut (
      .clk(clk), .rst(rst), .butt_n(butt_n), .pulse(pulse), .held(held)
   );

   button_conditioner #(
      .NUM_BUTTONS(NB), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(0), .REPEAT_CYCLES(REP)
   ) dut_nh (
      .clk(clk), .rst(rst), .butt_n(butt_n), .pulse(pulse_nh), .held(held_nh)
   );

   // ---------------- reference model ----------------
   // Model channels 0..NB-1 follow dut, NB..2NB-1 follow dut_nh (no repeat).
   bit m_da[2*NB], m_db[2*NB];      // raw samples still in flight to the FSM
   bit m_run_val[2*NB], m_pressed[2*NB], m_prev[2*NB];
   int m_run_len[2*NB], m_h[2*NB];
   logic [NB-1:0] exp_pulse, exp_held, exp_pulse_nh, exp_held_nh;

   task automatic model_reset();
      for (int k = 0; k < 2*NB; k++) begin
         m_da[k] = 1'b1; m_db[k] = 1'b1;
         m_run_val[k] = 1'b1; m_run_len[k] = 0;
         m_pressed[k] = 1'b0; m_prev[k] = 1'b1; m_h[k] = 0;
      end
      exp_pulse = '0; exp_held = '0; exp_pulse_nh = '0; exp_held_nh = '0;
   endtask

   // One clock edge: a press is accepted once DEB consecutive low samples
   // are seen, a release once DEB consecutive highs are seen. Hold time
   // counts edges whose preceding cycle was spent pressed with a low sample.
   task automatic model_edge();
      for (int k = 0; k < 2*NB; k++) begin
         int  hold_k;
         bit  seen;
         bit  p;
         hold_k = (k < NB) ? HOLD : 0;
         seen = m_da[k];
         m_da[k] = m_db[k];
         m_db[k] = butt_n[k % NB];
         if (seen == m_run_val[k]) m_run_len[k]++;
         else begin m_run_val[k] = seen; m_run_len[k] = 1; end
         p = 1'b0;
         if (!m_pressed[k]) begin
            if (m_run_val[k] == 1'b0 && m_run_len[k] >= DEB) begin
               m_pressed[k] = 1'b1; p = 1'b1; m_h[k] = 0;
            end
         end else begin
            if (m_prev[k] == 1'b0) begin
               m_h[k]++;
               if (hold_k > 0 && (m_h[k] == hold_k ||
                   (m_h[k] > hold_k && (m_h[k] - hold_k) % REP == 0)))
                  p = 1'b1;
            end
            if (m_run_val[k] == 1'b1 && m_run_len[k] >= DEB) m_pressed[k] = 1'b0;
         end
         m_prev[k] = seen;
         if (k < NB) begin
            exp_pulse[k] = p; exp_held[k] = m_pressed[k];
         end else begin
            exp_pulse_nh[k-NB] = p; exp_held_nh[k-NB] = m_pressed[k];
         end
      end
   endtask

   // ---------------- checking helpers ----------------
   task automatic check(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Drive at negedge, let the posedge sample it, compare 1 time unit later.
   task automatic step(input logic [NB-1:0] bn);
      @(negedge clk);
      butt_n = bn;
      @(posedge clk);
      if (!rst) model_edge();
      #1;
      check("pulse", pulse, exp_pulse);
      check("held", held, exp_held);
      check("pulse_nohold", pulse_nh, exp_pulse_nh);
      check("held_nohold", held_nh, exp_held_nh);
   endtask

   int pe[$];
   function automatic int pe_at(input int i);
      return (pe.size() > i) ? pe[i] : -1;
   endfunction

   int fall, cnt_nh, cnt_p1, drops, first;
   logic [NB-1:0] sim_vec, bn;
   int bounce[6] = '{0, 1, 0, 0, 1, 0};
   int rep_exp[7] = '{5, 15, 20, 25, 30, 35, 40};
   int gl_exp[3]  = '{5, 17, 22};

   initial begin
      model_reset();
      step(3'b111);
      step(3'b111);
      check("reset_pulse", pulse, 3'b000);
      check("reset_held", held, 3'b000);
      rst = 1'b0;
      for (int e = 0; e < 4; e++) step(3'b111);

      // Clean press and release on button 0.
      pe.delete(); fall = -1;
      for (int e = 0; e < 20; e++) begin
         step((e < 8) ? 3'b110 : 3'b111);
         if (pulse[0]) pe.push_back(e);
         if (e > 5 && !held[0] && fall < 0) fall = e;
      end
      check_int("clean_pulse_count", pe.size(), 1);
      check_int("clean_pulse_edge", pe_at(0), 5);
      check_int("clean_held_fall", fall, 13);

      // Bounce before a stable low.
      pe.delete();
      for (int e = 0; e < 16; e++) begin
         step((e < 6 && bounce[e] == 1) ? 3'b111 : 3'b110);
         if (pulse[0]) pe.push_back(e);
      end
      for (int e = 0; e < 10; e++) step(3'b111);
      check_int("bounce_pulse_count", pe.size(), 1);
      check_int("bounce_pulse_edge", pe_at(0), 10);

      // Auto-repeat on button 1, with and without repeat enabled.
      pe.delete(); cnt_nh = 0;
      for (int e = 0; e < 52; e++) begin
         step((e < 40) ? 3'b101 : 3'b111);
         if (pulse[1]) pe.push_back(e);
         if (pulse_nh[1]) cnt_nh++;
      end
      check_int("repeat_pulse_count", pe.size(), 7);
      for (int i = 0; i < 7; i++) check_int("repeat_pulse_edge", pe_at(i), rep_exp[i]);
      check_int("nohold_pulse_count", cnt_nh, 1);

      // Two-cycle release glitch while held.
      pe.delete(); drops = 0;
      for (int e = 0; e < 34; e++) begin
         step((e < 24 && e != 12 && e != 13) ? 3'b110 : 3'b111);
         if (pulse[0]) pe.push_back(e);
         if (e >= 5 && e <= 25 && !held[0]) drops++;
      end
      check_int("glitch_pulse_count", pe.size(), 3);
      for (int i = 0; i < 3; i++) check_int("glitch_pulse_edge", pe_at(i), gl_exp[i]);
      check_int("glitch_held_drops", drops, 0);

      // Simultaneous buttons 0 and 2.
      sim_vec = 3'b000; cnt_p1 = 0;
      for (int e = 0; e < 16; e++) begin
         step((e < 8) ? 3'b010 : 3'b111);
         if (e == 5) sim_vec = pulse;
         if (pulse[1]) cnt_p1++;
      end
      check("simul_pulse_vec", sim_vec, 3'b101);
      check_int("simul_pulse1_count", cnt_p1, 0);

      // Reset while button 0 is held.
      for (int e = 0; e < 18; e++) step(3'b110);
      check("pre_reset_held", held, 3'b001);
      rst = 1'b1;
      #1;
      model_reset();
      check("rst_async_pulse", pulse, 3'b000);
      check("rst_async_held", held, 3'b000);
      for (int e = 0; e < 3; e++) step(3'b110);
      rst = 1'b0;
      first = -1;
      for (int e = 1; e <= 12; e++) begin
         step(3'b110);
         if (pulse[0] && first < 0) first = e;
      end
      check_int("rst_repress_edge", first, DEB + 2);
      for (int e = 0; e < 10; e++) step(3'b111);

      // Random bouncing on all buttons.
      bn = 3'b111;
      for (int e = 0; e < 600; e++) begin
         for (int c = 0; c < NB; c++)
            if ($urandom_range(0, 11) == 0) bn[c] = ~bn[c];
         step(bn);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Per-button input conditioner for the clock/calendar front panel. It takes the raw, bouncing, active-low push-buttons (increase, decrease, change) and turns them into clean single-cycle `pulse` strobes with hold-to-repeat behaviour, plus a debounced `held` level. It sits directly upstream of the decade counter's set-mode logic, which consumes only the strobes. One independent channel is instantiated per button.

## Interface
- `NUM_BUTTONS`, default 3: number of independent channels.
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable samples needed to accept a press or a release (20 ms at 50 MHz). Must be at least 1.
- `HOLD_CYCLES`, default 25_000_000: cycles from the press pulse to the first repeat pulse. 0 disables auto-repeat.
- `REPEAT_CYCLES`, default 12_500_000: period of the repeat pulses after the first one. Must be at least 1.
- `clk` input 1: the single clock (50 MHz).
- `rst` input 1: reset, asynchronous, active-high.
- `butt_n` input NUM_BUTTONS: raw buttons, active-low (pressed = 0), asynchronous to `clk`.
- `pulse` output NUM_BUTTONS: one-cycle strobe per accepted press and per repeat.
- `held` output NUM_BUTTONS: debounced pressed level.

## Operation
- Each channel has a 2-flop synchronizer (`s1`, `s2`) followed by a 4-state FSM: IDLE, DEB_PRESS, PRESSED, DEB_RELEASE.
- **IDLE**
  - `s2` = 0 goes to DEB_PRESS with `cnt` = 1.
  - If DEBOUNCE_CYCLES = 1, the channel goes straight to PRESSED.
- **DEB_PRESS**
  - Each edge with `s2` = 0 increments `cnt`.
  - An edge with `s2` = 1 returns to IDLE. No pulse is produced.
  - The edge at which the count reaches DEBOUNCE_CYCLES goes to PRESSED, sets `pulse` = 1 for one cycle, sets `held` = 1 and clears the repeat counter `rcnt`.
- **PRESSED**
  - `rcnt` counts edges. At HOLD_CYCLES it emits a pulse, then one every REPEAT_CYCLES.
  - `s2` = 1 goes to DEB_RELEASE with `cnt` = 1. `rcnt` freezes.
- **DEB_RELEASE**
  - Consecutive `s2` = 1 edges reaching DEBOUNCE_CYCLES go to IDLE and set `held` = 0.
  - Any `s2` = 0 edge returns to PRESSED with no pulse. `rcnt` resumes from its frozen value.
  - No pulses are emitted in this state.
- Counters are sized by `$clog2` of the largest parameter plus 1. They saturate and never wrap.
- Channels are fully independent. Simultaneous presses on several buttons produce simultaneous pulses. Arbitration (for example increase and decrease together) belongs to the consumer.

## Timing
- **Reset values:** `pulse` = 0 and `held` = 0 on all channels. `s1`/`s2` = 1 (released). FSM = IDLE. `cnt` and `rcnt` = 0.
- **Press latency:** raw low sampled at edge E0 reaches `s2` at E1. The press pulse is registered at edge E0+DEBOUNCE_CYCLES+1 and is high for exactly that one cycle. `held` rises at the same edge.
- **Repeat pulses:** first at Ep+HOLD_CYCLES, where Ep is the press-pulse edge. Then at Ep+HOLD_CYCLES+k·REPEAT_CYCLES, assuming no release glitch.
- **Release latency:** `held` falls at edge R0+DEBOUNCE_CYCLES+1, where R0 is the edge that samples raw high.
- **Reset mid-operation:** outputs clear immediately, asynchronously. If the button is still held when `rst` deasserts, a full debounce is required and then a fresh press pulse is emitted.
- `pulse` is never high for two consecutive cycles.

## Structure
- Shared package `panel_pkg`:
  - the FSM state enum `btn_state_t` (IDLE, DEB_PRESS, PRESSED, DEB_RELEASE);
  - default timing constants `DEB_20MS`, `HOLD_0_5S`, `REP_0_25S` for a 50 MHz clock.
- Sub-module `button_channel`: one synchronizer, FSM and pair of counters. The top level is a generate loop over NUM_BUTTONS.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4, HOLD_CYCLES = 10 and REPEAT_CYCLES = 5, unless stated otherwise.

- **Clean press and release:** `butt_n[0]` goes low at E0 and is held for 8 cycles, then goes high.
  - Single pulse at E5; `held` high from E5 until 5 cycles after release.
  - No other pulses.
- **Bounce:** `butt_n[0]` toggles 0,1,0,0,1,0 then stays low.
  - Exactly one pulse, 5 edges after the final stable low sample.
  - No pulse during the bouncing.
- **Auto-repeat:** `butt_n[1]` is held low for 40 cycles.
  - Pulses at E5, E15, E20, E25, E30, E35, E40, none after release.
  - With HOLD_CYCLES = 0: only E5.
- **Release glitch:** channel in PRESSED; a 2-cycle high glitch at E12.
  - No pulse and `held` stays 1.
  - Repeat cadence is shifted by the 2 frozen cycles.
- **Simultaneous buttons:** `butt_n[0]` and `butt_n[2]` go low on the same edge.
  - Both channels pulse at the same edge; `pulse[1]` stays 0.
- **Reset mid-hold:** `rst` asserted for 3 cycles while `butt_n[0]` is held at E17.
  - `pulse` and `held` drop to 0 asynchronously.
  - After `rst` deasserts, a new pulse arrives DEBOUNCE_CYCLES+2 edges later.
